// File: rtl/morph_bin_kxk.sv
// Binary erode/dilate/bypass over a KxK window on a raster stream.
// The result is anchored bottom-right; out-of-frame taps take the operation's neutral value.
module morph_bin_kxk #(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 720,
  parameter int KSIZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vs,
  input  logic       in_de,
  input  logic [7:0] in_data,
  input  logic [1:0] mode,
  output logic       out_de,
  output logic [7:0] out_data,
  output logic       out_vs
);

  localparam int K  = KSIZE;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  generate
    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
      $error("morph_bin_kxk: KSIZE must be 3 or 5");
    end
  endgenerate

  logic          b_s;
  logic [CW-1:0] col_q, col_d, cur_col_s;
  logic [RW-1:0] row_q, row_d, cur_row_s;
  logic [1:0]    mode_q, mode_d, mode_eff_s;
  logic          is_erode_s;

  logic          lb_q [K-1][IMG_W];
  logic [K-2:0]  lb_rd_s;
  logic [K-1:0]  ent_s;
  logic [K-2:0]  win_q [K];
  logic [K-1:0]  taps_s [K];
  logic [K-1:0]  row_ok_s, col_ok_s;
  logic [K-1:0]  red_s;

  logic          s1_de_q, s1_vs_q, s1_byp_q;
  logic [1:0]    s1_mode_q;
  logic [K-1:0]  s1_red_q;
  logic          res_s;
  logic          out_de_q, out_vs_q;
  logic [7:0]    out_data_q;

  // Position and mode of the pixel presented this cycle; in_vs restarts the frame at (0,0).
  always_comb begin
    b_s        = |in_data;
    cur_col_s  = in_vs ? '0 : col_q;
    cur_row_s  = in_vs ? '0 : row_q;
    mode_eff_s = in_vs ? mode : mode_q;
    is_erode_s = (mode_eff_s == 2'b00);
    mode_d     = mode_eff_s;
    col_d      = cur_col_s;
    row_d      = cur_row_s;
    if (in_de) begin
      if (cur_col_s == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row_s == RW'(IMG_H - 1)) ? '0 : cur_row_s + RW'(1);
      end else begin
        col_d = cur_col_s + CW'(1);
      end
    end else begin
      col_d = cur_col_s;
    end
  end

  // Frame position counters and frame-latched mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 2'b00;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
    end
  end

  // Line buffer reads; buffer j holds the row j+1 lines above the current one.
  always_comb begin
    lb_rd_s = '0;
    for (int j = 0; j < K - 1; j++) begin
      lb_rd_s[j] = lb_q[j][cur_col_s];
    end
    ent_s = {lb_rd_s, b_s};
  end

  // Bit-packed line storage, read-before-write cascade; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_de) begin
      lb_q[0][cur_col_s] <= b_s;
      for (int j = 1; j < K - 1; j++) begin
        lb_q[j][cur_col_s] <= lb_rd_s[j-1];
      end
    end
  end

  // Window keeps the K-1 previous columns per row; the current column comes straight from ent_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        win_q[i] <= '0;
      end
    end else if (in_de) begin
      for (int i = 0; i < K; i++) begin
        win_q[i] <= {win_q[i][K-3:0], ent_s[i]};
      end
    end
  end

  // Stage 1 reductions per window row; taps before row/column 0 become the neutral value.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      taps_s[i]   = {win_q[i], ent_s[i]};
      row_ok_s[i] = (int'(cur_row_s) >= i);
      col_ok_s[i] = (int'(cur_col_s) >= i);
    end
    for (int i = 0; i < K; i++) begin
      red_s[i] = is_erode_s;
      for (int j = 0; j < K; j++) begin
        if (row_ok_s[i] && col_ok_s[j]) begin
          red_s[i] = is_erode_s ? (red_s[i] & taps_s[i][j]) : (red_s[i] | taps_s[i][j]);
        end else begin
          red_s[i] = red_s[i];
        end
      end
    end
  end

  // Stage 1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_de_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_byp_q  <= 1'b0;
      s1_mode_q <= 2'b00;
      s1_red_q  <= '0;
    end else begin
      s1_de_q <= in_de;
      s1_vs_q <= in_vs;
      if (in_de) begin
        s1_byp_q  <= b_s;
        s1_mode_q <= mode_eff_s;
        s1_red_q  <= red_s;
      end
    end
  end

  // Stage 2 row combine.
  always_comb begin
    case (s1_mode_q)
      2'b00:   res_s = &s1_red_q;
      2'b01:   res_s = |s1_red_q;
      default: res_s = s1_byp_q;
    endcase
  end

  // Output register; data holds while no valid pixel leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de_q   <= 1'b0;
      out_vs_q   <= 1'b0;
      out_data_q <= 8'h00;
    end else begin
      out_de_q <= s1_de_q;
      out_vs_q <= s1_vs_q;
      if (s1_de_q) begin
        out_data_q <= res_s ? 8'hFF : 8'h00;
      end
    end
  end

  assign out_de   = out_de_q;
  assign out_vs   = out_vs_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_morph_bin_kxk.sv
// Bench for morph_bin_kxk: K=3 and K=5 instances on a shared 8x6 stream, checked
// against fixed expected regions and a frame-array reference model.
module tb_morph_bin_kxk;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int FULL = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vs = 1'b0, in_de = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       o3_de, o3_vs, o5_de, o5_vs;
  logic [7:0] o3_data, o5_data;

  int n_chk = 0;
  int n_err = 0;

  logic img [H][W];
  logic [7:0] q3[$];
  logic [7:0] q5[$];
  int tbl_k = 0;
  int t_r0, t_r1, t_c0, t_c1;
  logic [7:0] t_in, t_out;

  logic de_h1 = 1'b0, de_h2 = 1'b0, vs_h1 = 1'b0, vs_h2 = 1'b0;

  typedef struct {
    logic [1:0] mode;
    logic       fill;
    int         pr, pc;
    int         k;
    int         r0, r1, c0, c1;
    logic [7:0] inv, outv;
    int         gap;
  } vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  morph_bin_kxk #(.IMG_W(W), .IMG_H(H), .KSIZE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .mode(mode), .out_de(o3_de), .out_data(o3_data), .out_vs(o3_vs));

  morph_bin_kxk #(.IMG_W(W), .IMG_H(H), .KSIZE(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .mode(mode), .out_de(o5_de), .out_data(o5_data), .out_vs(o5_vs));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: erode = AND, dilate = OR over the KxK block ending at (r,c); outside frame is neutral.
  function automatic logic [7:0] model_px(input int k, input logic [1:0] m, input int r, input int c);
    logic erode, acc, v;
    if (m[1]) return img[r][c] ? 8'hFF : 8'h00;
    erode = (m == 2'b00);
    acc   = erode;
    for (int dr = 0; dr < k; dr++) begin
      for (int dc = 0; dc < k; dc++) begin
        if (r - dr < 0 || c - dc < 0) v = erode;
        else                          v = img[r-dr][c-dc];
        acc = erode ? (acc & v) : (acc | v);
      end
    end
    return acc ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] expect_px(input int k, input logic [1:0] m, input int r, input int c);
    if (tbl_k == k) begin
      return (r >= t_r0 && r <= t_r1 && c >= t_c0 && c <= t_c1) ? t_in : t_out;
    end
    return model_px(k, m, r, c);
  endfunction

  task automatic drive_cyc(input logic vs, input logic de, input logic [7:0] d, input logic [1:0] m);
    @(posedge clk);
    #1;
    in_vs   = vs;
    in_de   = de;
    in_data = d;
    mode    = m;
  endtask

  task automatic drive_frame(input logic [1:0] fm, input logic [1:0] late_m, input int switch_at,
                             input int gap_pct, input int npix);
    int         n;
    bit         vs_pend;
    logic [1:0] m;
    logic [7:0] d;
    n = 0;
    vs_pend = 1'b1;
    m = fm;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
          drive_cyc(vs_pend, 1'b0, 8'h00, m);
          vs_pend = 1'b0;
        end
        d = img[r][c] ? 8'($urandom_range(1, 255)) : 8'h00;
        q3.push_back(expect_px(3, fm, r, c));
        q5.push_back(expect_px(5, fm, r, c));
        drive_cyc(vs_pend, 1'b1, d, m);
        vs_pend = 1'b0;
        n++;
        if (n == switch_at) m = late_m;
        if (n == npix) return;
      end
    end
  endtask

  task automatic fill_random(input int dens);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (int'($urandom_range(0, 99)) < dens);
  endtask

  // Inputs seen at each active edge, delayed twice, give the required out_de/out_vs.
  always @(posedge clk) begin
    if (!rst_n) begin
      de_h1 = 1'b0; de_h2 = 1'b0; vs_h1 = 1'b0; vs_h2 = 1'b0;
    end else begin
      de_h2 = de_h1; de_h1 = in_de;
      vs_h2 = vs_h1; vs_h1 = in_vs;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_de3", {7'd0, o3_de}, 8'h00);
      chk("rst_vs3", {7'd0, o3_vs}, 8'h00);
      chk("rst_data3", o3_data, 8'h00);
      chk("rst_de5", {7'd0, o5_de}, 8'h00);
      chk("rst_data5", o5_data, 8'h00);
      q3.delete();
      q5.delete();
    end else begin
      chk("de3", {7'd0, o3_de}, {7'd0, de_h2});
      chk("vs3", {7'd0, o3_vs}, {7'd0, vs_h2});
      chk("de5", {7'd0, o5_de}, {7'd0, de_h2});
      chk("vs5", {7'd0, o5_vs}, {7'd0, vs_h2});
      if (de_h2) begin
        if (q3.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL data3: got %h expected none queued at %0t", o3_data, $time);
        end else begin
          chk("data3", o3_data, q3.pop_front());
        end
        if (q5.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL data5: got %h expected none queued at %0t", o5_data, $time);
        end else begin
          chk("data5", o5_data, q5.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        mode   fill  pr  pc  k  r0  r1  c0  c1  inside outside gap
    vt[0] = '{2'b00, 1'b1, -1, -1, 3, -1, -2, -1, -2, 8'h00, 8'hFF, 0};
    vt[1] = '{2'b00, 1'b1,  2,  3, 3,  2,  4,  3,  5, 8'h00, 8'hFF, 0};
    vt[2] = '{2'b01, 1'b0,  1,  1, 5,  1,  5,  1,  5, 8'hFF, 8'h00, 0};
    vt[3] = '{2'b01, 1'b0,  1,  1, 5,  1,  5,  1,  5, 8'hFF, 8'h00, 0};
    vt[4] = '{2'b01, 1'b0,  1,  1, 5,  1,  5,  1,  5, 8'hFF, 8'h00, 30};
    vt[5] = '{2'b10, 1'b0,  3,  4, 3,  3,  3,  4,  4, 8'hFF, 8'h00, 0};
    vt[6] = '{2'b11, 1'b1,  0,  0, 5,  0,  0,  0,  0, 8'h00, 8'hFF, 20};
    vt[7] = '{2'b00, 1'b1,  4,  6, 5,  4,  5,  6,  7, 8'h00, 8'hFF, 0};
    vt[8] = '{2'b01, 1'b0,  5,  7, 3,  5,  5,  7,  7, 8'hFF, 8'h00, 0};
    vt[9] = '{2'b00, 1'b1,  5,  7, 3,  5,  5,  7,  7, 8'h00, 8'hFF, 30};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) drive_cyc(1'b0, 1'b0, 8'h00, 2'b00);

    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = vt[i].fill;
      if (vt[i].pr >= 0) img[vt[i].pr][vt[i].pc] = ~vt[i].fill;
      tbl_k = vt[i].k;
      t_r0 = vt[i].r0; t_r1 = vt[i].r1; t_c0 = vt[i].c0; t_c1 = vt[i].c1;
      t_in = vt[i].inv; t_out = vt[i].outv;
      drive_frame(vt[i].mode, vt[i].mode, -1, vt[i].gap, FULL);
    end
    tbl_k = 0;

    // Mid-frame mode change only takes effect at the next frame start.
    fill_random(60);
    drive_frame(2'b00, 2'b01, 10, 0, FULL);
    fill_random(30);
    drive_frame(2'b01, 2'b01, -1, 0, FULL);
    repeat (3) drive_cyc(1'b0, 1'b0, 8'h00, 2'b01);

    for (int f = 0; f < 8; f++) begin
      fill_random(int'($urandom_range(15, 85)));
      drive_frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  int'($urandom_range(1, FULL)), int'($urandom_range(0, 40)), FULL);
    end

    // Reset mid-line, then a clean frame must match exactly.
    fill_random(50);
    drive_frame(2'b01, 2'b01, -1, 0, 13);
    @(posedge clk);
    #1;
    rst_n = 1'b0; in_de = 1'b0; in_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_random(70);
    drive_frame(2'b00, 2'b00, -1, 10, FULL);

    repeat (5) drive_cyc(1'b0, 1'b0, 8'h00, 2'b00);
    chk("q3_left", 8'(q3.size()), 8'h00);
    chk("q5_left", 8'(q5.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
